// File: rtl/pixel_pkg.sv
// Shared definitions for the 8-digit 7-segment scan controller: digit
// numbering, scan state encoding and the one-hot anode helper.
package pixel_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam int          SEL_W      = 3;
    localparam logic [7:0]  ANODE_OFF  = 8'hFF;

    // Digit positions as seen by the address/data nibble mux.
    localparam logic [SEL_W-1:0] DIG_DATA0   = 3'd0;
    localparam logic [SEL_W-1:0] DIG_DATA1   = 3'd1;
    localparam logic [SEL_W-1:0] DIG_DATA2   = 3'd2;
    localparam logic [SEL_W-1:0] DIG_DATA3   = 3'd3;
    localparam logic [SEL_W-1:0] DIG_ADDR_LO = 3'd4;
    localparam logic [SEL_W-1:0] DIG_ADDR_HI = 3'd5;

    // Scan state; the encoding doubles as the seg_sel value.
    typedef enum logic [SEL_W-1:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } scan_state_t;

    // Active-high one-hot of a digit index (bit sel set).
    function automatic logic [NUM_DIGITS-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [NUM_DIGITS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pixel_scan_ctrl_if.sv
// Display-side bundle of the scan controller: enable and digit mask in,
// digit select, anode drive and slot pulse out.
interface pixel_scan_ctrl_if;
    import pixel_pkg::*;

    logic                  en;
    logic [NUM_DIGITS-1:0] digit_mask;
    logic [SEL_W-1:0]      seg_sel;
    logic [NUM_DIGITS-1:0] anode;
    logic                  slot_tick;

    // Host side: sets enable/mask and observes the scan.
    modport master (
        output en, digit_mask,
        input  seg_sel, anode, slot_tick
    );

    // Scan controller side.
    modport slave (
        input  en, digit_mask,
        output seg_sel, anode, slot_tick
    );

endinterface

// File: rtl/refresh_tick_gen.sv
// Digit-slot timer: counts 0..TICK_DIV-1 while enabled and flags the last
// cycle of each slot. The running count is exported for dead-time logic.
module refresh_tick_gen #(
    parameter int TICK_DIV = 100000,
    localparam int CNT_W   = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    // Last cycle of the slot; suppressed while the scan is frozen.
    assign tick = en && (count == LAST);

    // Slot counter: advances only when enabled, holds its value otherwise.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// 8-digit 7-segment scan controller. Walks seg_sel 0..7 at one digit per
// TICK_DIV cycles and drives the matching active-low anode, gated by the
// per-digit mask and the scan enable.
// Build option GHOST_BLANK_EN: holds all anodes off for the first
// DEAD_CYCLES cycles of every slot to hide segment/anode skew.
module pixel_scan_ctrl
    import pixel_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    pixel_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(TICK_DIV);

`ifdef GHOST_BLANK_EN
    localparam int DEAD_EFF = DEAD_CYCLES;
`else
    localparam int DEAD_EFF = 0;
`endif

    logic                  tick;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        count_inc;
    logic                  dead_next;
    scan_state_t           state, state_next;
    logic [NUM_DIGITS-1:0] anode_q, anode_next;
    logic                  slot_tick_q;

    refresh_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (bus.en),
        .tick    (tick),
        .count   (count)
    );

    // Dead-time applies when the count after this edge is below DEAD_EFF;
    // a wrapping tick always lands on count 0.
    assign count_inc = {1'b0, count} + 1'b1;
    assign dead_next = (DEAD_EFF > 0) &&
                       (tick || (count_inc < (CNT_W+1)'(DEAD_EFF)));

    // Next scan state and next anode pattern, computed from the post-edge
    // state so seg_sel and anode change on the same edge.
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        anode_next = ANODE_OFF;
        if (tick) begin
            state_next = scan_state_t'(state + 3'd1);
        end
        if (bus.en && !dead_next) begin
            anode_next = ~(onehot8(state_next) & bus.digit_mask);
        end
    end

    // Scan state, anode drive and slot pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S0;
            anode_q     <= ANODE_OFF;
            slot_tick_q <= 1'b0;
        end else begin
            state       <= state_next;
            anode_q     <= anode_next;
            slot_tick_q <= tick;
        end
    end

    assign bus.seg_sel   = state;
    assign bus.anode     = anode_q;
    assign bus.slot_tick = slot_tick_q;

endmodule
